// File: rtl/ddr_cmd_sequencer_if.sv
// Request/command bundle between the transaction generator, the sequencer and the DIMM side.
// master = requester/observer side, slave = sequencer side.
interface ddr_cmd_sequencer_if #(
  parameter int unsigned ROW_W  = 16,
  parameter int unsigned COL_W  = 10,
  parameter int unsigned BANK_W = 4
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [BANK_W-1:0] req_bank;
  logic [ROW_W-1:0]  req_row;
  logic [COL_W-1:0]  req_col;
  logic              mrs_update;
  logic [1:0]        bl_update;
  logic              cmd_valid;
  logic [2:0]        cmd_code;
  logic [BANK_W-1:0] cmd_bank;
  logic [ROW_W-1:0]  cmd_addr;
  logic              act_cmd;
  logic              dev_busy;
  logic              rw_proc;
  logic [1:0]        dev_rw;
  logic              next_cmd;
  logic [1:0]        cur_bl;

  modport master (
    output req_valid, req_rw, req_bank, req_row, req_col, mrs_update, bl_update,
    input  req_ready, cmd_valid, cmd_code, cmd_bank, cmd_addr, act_cmd, dev_busy, rw_proc,
           dev_rw, next_cmd, cur_bl
  );

  modport slave (
    input  req_valid, req_rw, req_bank, req_row, req_col, mrs_update, bl_update,
    output req_ready, cmd_valid, cmd_code, cmd_bank, cmd_addr, act_cmd, dev_busy, rw_proc,
           dev_rw, next_cmd, cur_bl
  );
endinterface

// File: rtl/ddr_cmd_sequencer.sv
// Closed-page DDR4 command sequencer: ACT -> RD/WR -> PRE per request, MRS for MR0 BL updates.
// All outputs registered except req_ready; one shared 8-bit down-counter times every wait.
module ddr_cmd_sequencer #(
  parameter int unsigned ROW_W  = 16,
  parameter int unsigned COL_W  = 10,
  parameter int unsigned BANK_W = 4,
  parameter int unsigned T_RCD  = 4,
  parameter int unsigned T_CL   = 5,
  parameter int unsigned T_CWL  = 4,
  parameter int unsigned T_RP   = 4,
  parameter int unsigned T_MOD  = 6
) (
  input logic                clock,
  input logic                reset,
  ddr_cmd_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    StIdle, StAct, StRcdWait, StRw, StDataWait, StPre, StRpWait, StMrs, StModWait
  } state_e;

  typedef enum logic [2:0] {
    CmdNop = 3'd0, CmdAct = 3'd1, CmdRd = 3'd2, CmdWr = 3'd3, CmdPre = 3'd4, CmdMrs = 3'd5
  } cmd_e;

  // Loads are gap-1 because the command cycle itself counts as the first cycle of the gap.
  localparam logic [7:0] RcdLoad = 8'(T_RCD - 1);
  localparam logic [7:0] RdLoad  = 8'(T_CL - 1);
  localparam logic [7:0] WrLoad  = 8'(T_CWL - 1);
  localparam logic [7:0] RpLoad  = 8'(T_RP - 1);
  localparam logic [7:0] ModLoad = 8'(T_MOD - 1);

  state_e            state_q;
  logic [7:0]        cnt_q;
  logic              burst_q;
  logic              bc4_q;
  logic              mrs_pend_q;
  logic [1:0]        mrs_bl_q;
  logic [1:0]        cur_bl_q;
  logic              rw_q;
  logic [BANK_W-1:0] bank_q;
  logic [COL_W-1:0]  col_q;

  logic              cmd_valid_q;
  cmd_e              cmd_code_q;
  logic [BANK_W-1:0] cmd_bank_q;
  logic [ROW_W-1:0]  cmd_addr_q;
  logic              act_cmd_q;
  logic              dev_busy_q;
  logic              rw_proc_q;
  logic [1:0]        dev_rw_q;
  logic              next_cmd_q;

  logic [1:0]        mrs_code;

  // A pulse arriving in the same cycle overrides the captured code (last wins).
  assign mrs_code      = bus.mrs_update ? bus.bl_update : mrs_bl_q;
  assign bus.req_ready = (state_q == StIdle) && !mrs_pend_q && !bus.mrs_update && !reset;

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_code  = cmd_code_q;
  assign bus.cmd_bank  = cmd_bank_q;
  assign bus.cmd_addr  = cmd_addr_q;
  assign bus.act_cmd   = act_cmd_q;
  assign bus.dev_busy  = dev_busy_q;
  assign bus.rw_proc   = rw_proc_q;
  assign bus.dev_rw    = dev_rw_q;
  assign bus.next_cmd  = next_cmd_q;
  assign bus.cur_bl    = cur_bl_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      burst_q     <= 1'b0;
      bc4_q       <= 1'b0;
      mrs_pend_q  <= 1'b0;
      mrs_bl_q    <= '0;
      cur_bl_q    <= '0;
      rw_q        <= 1'b0;
      bank_q      <= '0;
      col_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= CmdNop;
      cmd_bank_q  <= '0;
      cmd_addr_q  <= '0;
      act_cmd_q   <= 1'b0;
      dev_busy_q  <= 1'b0;
      rw_proc_q   <= 1'b0;
      dev_rw_q    <= '0;
      next_cmd_q  <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= CmdNop;
      cmd_bank_q  <= '0;
      cmd_addr_q  <= '0;
      act_cmd_q   <= 1'b0;
      next_cmd_q  <= 1'b0;

      if (bus.mrs_update && (state_q != StIdle)) begin
        mrs_pend_q <= 1'b1;
        mrs_bl_q   <= bus.bl_update;
      end

      case (state_q)
        StIdle: begin
          if (bus.mrs_update || mrs_pend_q) begin
            mrs_pend_q <= 1'b0;
            if (mrs_code != 2'b11) begin
              state_q     <= StMrs;
              cnt_q       <= ModLoad;
              cmd_valid_q <= 1'b1;
              cmd_code_q  <= CmdMrs;
              cmd_addr_q  <= ROW_W'(mrs_code);
              cur_bl_q    <= mrs_code;
              dev_busy_q  <= 1'b1;
            end
          end else if (bus.req_valid) begin
            rw_q        <= bus.req_rw;
            bank_q      <= bus.req_bank;
            col_q       <= bus.req_col;
            state_q     <= StAct;
            cnt_q       <= RcdLoad;
            cmd_valid_q <= 1'b1;
            cmd_code_q  <= CmdAct;
            cmd_bank_q  <= bus.req_bank;
            cmd_addr_q  <= bus.req_row;
            act_cmd_q   <= 1'b1;
            dev_busy_q  <= 1'b1;
            rw_proc_q   <= 1'b1;
          end
        end

        StAct, StRcdWait: begin
          if (cnt_q != 8'd0) begin
            state_q <= StRcdWait;
            cnt_q   <= cnt_q - 8'd1;
          end else begin
            state_q     <= StRw;
            cnt_q       <= rw_q ? RdLoad : WrLoad;
            burst_q     <= 1'b0;
            bc4_q       <= (cur_bl_q == 2'b10);
            cmd_valid_q <= 1'b1;
            cmd_code_q  <= rw_q ? CmdRd : CmdWr;
            cmd_bank_q  <= bank_q;
            cmd_addr_q  <= ROW_W'(col_q);
            dev_rw_q    <= rw_q ? 2'b10 : 2'b01;
          end
        end

        // Latency phase first, then a burst phase whose length was fixed at the RD/WR cycle.
        StRw, StDataWait: begin
          state_q <= StDataWait;
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else if (!burst_q) begin
            burst_q <= 1'b1;
            cnt_q   <= bc4_q ? 8'd1 : 8'd3;
          end else begin
            state_q     <= StPre;
            cnt_q       <= RpLoad;
            cmd_valid_q <= 1'b1;
            cmd_code_q  <= CmdPre;
            cmd_bank_q  <= bank_q;
            dev_rw_q    <= 2'b00;
          end
        end

        StPre, StRpWait: begin
          rw_proc_q <= 1'b0;
          if (cnt_q != 8'd0) begin
            state_q <= StRpWait;
            cnt_q   <= cnt_q - 8'd1;
          end else begin
            state_q    <= StIdle;
            dev_busy_q <= 1'b0;
            next_cmd_q <= 1'b1;
          end
        end

        StMrs, StModWait: begin
          if (cnt_q != 8'd0) begin
            state_q <= StModWait;
            cnt_q   <= cnt_q - 8'd1;
          end else begin
            state_q    <= StIdle;
            dev_busy_q <= 1'b0;
            next_cmd_q <= 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Directed bench for ddr_cmd_sequencer at default timing: logs each cycle of a scenario,
// then compares command cycles and status flags against hand-derived values.
module tb_ddr_cmd_sequencer;

  localparam int unsigned LogN = 64;

  logic clock;
  logic reset;
  int   n_total;
  int   n_bad;

  ddr_cmd_sequencer_if #(.ROW_W(16), .COL_W(10), .BANK_W(4)) bus ();

  ddr_cmd_sequencer #(
    .ROW_W (16),
    .COL_W (10),
    .BANK_W(4),
    .T_RCD (4),
    .T_CL  (5),
    .T_CWL (4),
    .T_RP  (4),
    .T_MOD (6)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic        l_valid [LogN];
  logic [2:0]  l_code  [LogN];
  logic [3:0]  l_bank  [LogN];
  logic [15:0] l_addr  [LogN];
  logic        l_act   [LogN];
  logic        l_busy  [LogN];
  logic        l_rwp   [LogN];
  logic [1:0]  l_devrw [LogN];
  logic        l_next  [LogN];
  logic [1:0]  l_bl    [LogN];
  logic        l_ready [LogN];

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rec(input int i);
    l_valid[i] = bus.cmd_valid;
    l_code[i]  = bus.cmd_code;
    l_bank[i]  = bus.cmd_bank;
    l_addr[i]  = bus.cmd_addr;
    l_act[i]   = bus.act_cmd;
    l_busy[i]  = bus.dev_busy;
    l_rwp[i]   = bus.rw_proc;
    l_devrw[i] = bus.dev_rw;
    l_next[i]  = bus.next_cmd;
    l_bl[i]    = bus.cur_bl;
    l_ready[i] = bus.req_ready;
  endtask

  // Cycle 0 presents the request (held until accepted); optional MRS pulse and reset cycle.
  task automatic run(input int n, input logic do_req, input logic rw, input logic [3:0] bank,
                     input logic [15:0] row, input logic [9:0] col, input int mrs_at,
                     input logic [1:0] mrs_bl, input int rst_at);
    logic pend;
    pend = do_req;
    for (int i = 0; i <= n; i++) begin
      tick();
      bus.req_valid  = pend;
      bus.req_rw     = rw;
      bus.req_bank   = bank;
      bus.req_row    = row;
      bus.req_col    = col;
      bus.mrs_update = (i == mrs_at);
      bus.bl_update  = mrs_bl;
      reset          = (i == rst_at);
      #1;
      rec(i);
      if (pend && bus.req_ready) pend = 1'b0;
    end
    bus.req_valid  = 1'b0;
    bus.mrs_update = 1'b0;
    reset          = 1'b0;
  endtask

  function automatic int find_cmd(input logic [2:0] code, input int from, input int to);
    for (int i = from; i <= to; i++) if (l_valid[i] && l_code[i] == code) return i;
    return -1;
  endfunction

  function automatic int find_next(input int from, input int to);
    for (int i = from; i <= to; i++) if (l_next[i]) return i;
    return -1;
  endfunction

  function automatic int count_valid(input int from, input int to);
    int c;
    c = 0;
    for (int i = from; i <= to; i++) if (l_valid[i]) c++;
    return c;
  endfunction

  function automatic int count_rwp(input int from, input int to);
    int c;
    c = 0;
    for (int i = from; i <= to; i++) if (l_rwp[i]) c++;
    return c;
  endfunction

  initial begin
    n_total        = 0;
    n_bad          = 0;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_rw     = 1'b0;
    bus.req_bank   = '0;
    bus.req_row    = '0;
    bus.req_col    = '0;
    bus.mrs_update = 1'b0;
    bus.bl_update  = '0;

    // Reset state
    tick();
    tick();
    check("rst_cmd_valid", int'(bus.cmd_valid), 0);
    check("rst_cmd_code",  int'(bus.cmd_code), 0);
    check("rst_cmd_addr",  int'(bus.cmd_addr), 0);
    check("rst_dev_busy",  int'(bus.dev_busy), 0);
    check("rst_rw_proc",   int'(bus.rw_proc), 0);
    check("rst_dev_rw",    int'(bus.dev_rw), 0);
    check("rst_cur_bl",    int'(bus.cur_bl), 0);
    check("rst_req_ready", int'(bus.req_ready), 0);

    // Read BL8: ACT 1, RD 5, PRE 14, IDLE 18
    run(20, 1'b1, 1'b1, 4'd3, 16'h1234, 10'h055, -1, 2'b00, -1);
    check("rd_ready0",    int'(l_ready[0]), 1);
    check("rd_act_cyc",   find_cmd(3'd1, 0, 20), 1);
    check("rd_act_bank",  int'(l_bank[1]), 3);
    check("rd_act_row",   int'(l_addr[1]), 'h1234);
    check("rd_act_cmd",   int'(l_act[1]), 1);
    check("rd_rd_cyc",    find_cmd(3'd2, 0, 20), 5);
    check("rd_rd_col",    int'(l_addr[5]), 'h055);
    check("rd_devrw5",    int'(l_devrw[5]), 2);
    check("rd_devrw13",   int'(l_devrw[13]), 2);
    check("rd_devrw14",   int'(l_devrw[14]), 0);
    check("rd_pre_cyc",   find_cmd(3'd4, 0, 20), 14);
    check("rd_pre_bank",  int'(l_bank[14]), 3);
    check("rd_ncmds",     count_valid(0, 20), 3);
    check("rd_rwproc_n",  count_rwp(0, 20), 14);
    check("rd_rwproc1",   int'(l_rwp[1]), 1);
    check("rd_busy17",    int'(l_busy[17]), 1);
    check("rd_next_cyc",  find_next(0, 20), 18);
    check("rd_ready17",   int'(l_ready[17]), 0);
    check("rd_ready18",   int'(l_ready[18]), 1);
    check("rd_busy18",    int'(l_busy[18]), 0);

    // Write BL8: WR 5, dev_rw=01 through 12, PRE 13, IDLE 17
    run(20, 1'b1, 1'b0, 4'd5, 16'h00ab, 10'h3ff, -1, 2'b00, -1);
    check("wr_wr_cyc",    find_cmd(3'd3, 0, 20), 5);
    check("wr_wr_col",    int'(l_addr[5]), 'h3ff);
    check("wr_devrw12",   int'(l_devrw[12]), 1);
    check("wr_devrw13",   int'(l_devrw[13]), 0);
    check("wr_pre_cyc",   find_cmd(3'd4, 0, 20), 13);
    check("wr_next_cyc",  find_next(0, 20), 17);

    // MRS BC4 in IDLE: MRS at 1 with addr 2, next_cmd at 7
    run(10, 1'b0, 1'b0, 4'd0, 16'h0, 10'h0, 0, 2'b10, -1);
    check("mrs_ready0",   int'(l_ready[0]), 0);
    check("mrs_cyc",      find_cmd(3'd5, 0, 10), 1);
    check("mrs_addr",     int'(l_addr[1]), 2);
    check("mrs_bl0",      int'(l_bl[0]), 0);
    check("mrs_bl1",      int'(l_bl[1]), 2);
    check("mrs_next",     find_next(0, 10), 7);
    check("mrs_ready6",   int'(l_ready[6]), 0);
    check("mrs_ready7",   int'(l_ready[7]), 1);

    // Read with BC4: PRE 12
    run(20, 1'b1, 1'b1, 4'd1, 16'h0042, 10'h010, -1, 2'b00, -1);
    check("bc4_pre_cyc",  find_cmd(3'd4, 0, 20), 12);
    check("bc4_next",     find_next(0, 20), 16);

    // MRS (BL8) during RCD_WAIT of a BC4 read: read unchanged, MRS at 17, ready at 23
    run(28, 1'b1, 1'b1, 4'd2, 16'h0777, 10'h001, 2, 2'b00, -1);
    check("mid_pre_cyc",  find_cmd(3'd4, 0, 28), 12);
    check("mid_next1",    find_next(0, 28), 16);
    check("mid_ready16",  int'(l_ready[16]), 0);
    check("mid_mrs_cyc",  find_cmd(3'd5, 0, 28), 17);
    check("mid_bl16",     int'(l_bl[16]), 2);
    check("mid_bl17",     int'(l_bl[17]), 0);
    check("mid_ready22",  int'(l_ready[22]), 0);
    check("mid_next2",    find_next(17, 28), 23);
    check("mid_ready23",  int'(l_ready[23]), 1);

    // MRS and request together: MRS 1, accept at 7, ACT 8, BC4 PRE 19
    run(26, 1'b1, 1'b1, 4'd6, 16'h0abc, 10'h020, 0, 2'b10, -1);
    check("both_ready0",  int'(l_ready[0]), 0);
    check("both_mrs_cyc", find_cmd(3'd5, 0, 26), 1);
    check("both_act_cyc", find_cmd(3'd1, 0, 26), 8);
    check("both_act_bnk", int'(l_bank[8]), 6);
    check("both_pre_cyc", find_cmd(3'd4, 0, 26), 19);
    check("both_next2",   find_next(8, 26), 23);

    // Reserved BL code: nothing happens
    run(5, 1'b0, 1'b0, 4'd0, 16'h0, 10'h0, 0, 2'b11, -1);
    check("rsv_ncmds",    count_valid(0, 5), 0);
    check("rsv_bl3",      int'(l_bl[3]), 2);
    check("rsv_next",     find_next(0, 5), -1);
    check("rsv_ready1",   int'(l_ready[1]), 1);

    // Reset in DATA_WAIT of a write: everything clears, no PRE
    run(20, 1'b1, 1'b0, 4'd9, 16'h0101, 10'h002, -1, 2'b00, 7);
    check("rstm_rwp7",    int'(l_rwp[7]), 1);
    check("rstm_ready7",  int'(l_ready[7]), 0);
    check("rstm_busy8",   int'(l_busy[8]), 0);
    check("rstm_rwp8",    int'(l_rwp[8]), 0);
    check("rstm_devrw8",  int'(l_devrw[8]), 0);
    check("rstm_valid8",  int'(l_valid[8]), 0);
    check("rstm_bl8",     int'(l_bl[8]), 0);
    check("rstm_pre",     find_cmd(3'd4, 0, 20), -1);
    check("rstm_ready8",  int'(l_ready[8]), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
